pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL lock acquisition controller.
// Holds the PLL in reset, waits for a debounced lock, and releases downstream
// logic once lock is stable. It retries on timeout, gives up after a bounded
// number of attempts, and restarts acquisition when lock is lost or on request.
// All outputs are registered. They are computed from the next state, so each
// output changes on the same edge as the state it belongs to.
module pll_lock_ctrl #(
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 256,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        DEBOUNCE  = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // Saturating increment for the lock-loss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic          sync1_r;
    logic          lock_s;
    logic [RW-1:0] rst_cnt_r;
    logic [RW-1:0] rst_cnt_nxt_s;
    logic [TW-1:0] to_cnt_r;
    logic [TW-1:0] to_cnt_nxt_s;
    logic [SW-1:0] stb_cnt_r;
    logic [SW-1:0] stb_cnt_nxt_s;
    logic [3:0]    retry_nxt_s;
    logic [7:0]    lost_nxt_s;
    logic          to_fire_s;
    logic          pll_reset_nxt_s;
    logic          sys_reset_n_nxt_s;
    logic          ready_nxt_s;
    logic          fail_nxt_s;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_r <= pll_lock;
            lock_s  <= sync1_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= PLL_RST;
            rst_cnt_r   <= {RW{1'b0}};
            to_cnt_r    <= {TW{1'b0}};
            stb_cnt_r   <= {SW{1'b0}};
            retry_cnt   <= 4'd0;
            lost_cnt    <= 8'd0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rst_cnt_r   <= rst_cnt_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
            stb_cnt_r   <= stb_cnt_nxt_s;
            retry_cnt   <= retry_nxt_s;
            lost_cnt    <= lost_nxt_s;
            pll_reset   <= pll_reset_nxt_s;
            sys_reset_n <= sys_reset_n_nxt_s;
            ready       <= ready_nxt_s;
            fail        <= fail_nxt_s;
        end
    end

    // Next-state, counter updates and output decode.
    always_comb begin
        state_nxt_s   = state_r;
        rst_cnt_nxt_s = rst_cnt_r;
        to_cnt_nxt_s  = to_cnt_r;
        stb_cnt_nxt_s = stb_cnt_r;
        retry_nxt_s   = retry_cnt;
        lost_nxt_s    = lost_cnt;
        to_fire_s     = 1'b0;

        if (relock_req) begin
            state_nxt_s   = PLL_RST;
            rst_cnt_nxt_s = {RW{1'b0}};
            retry_nxt_s   = 4'd0;
        end else begin
            case (state_r)
                PLL_RST: begin
                    if (rst_cnt_r == RST_LAST) begin
                        state_nxt_s   = WAIT_LOCK;
                        rst_cnt_nxt_s = {RW{1'b0}};
                        to_cnt_nxt_s  = {TW{1'b0}};
                    end else begin
                        rst_cnt_nxt_s = rst_cnt_r + RW'(1'b1);
                    end
                end
                WAIT_LOCK: begin
                    if (to_cnt_r == TO_LAST) begin
                        to_fire_s = 1'b1;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r + TW'(1'b1);
                        if (lock_s) begin
                            state_nxt_s   = DEBOUNCE;
                            stb_cnt_nxt_s = {SW{1'b0}};
                        end else begin
                            state_nxt_s = WAIT_LOCK;
                        end
                    end
                end
                DEBOUNCE: begin
                    // A completed debounce beats a timeout on the same edge.
                    if (lock_s && (stb_cnt_r == STB_LAST)) begin
                        state_nxt_s = RUN;
                        retry_nxt_s = 4'd0;
                    end else if (to_cnt_r == TO_LAST) begin
                        to_fire_s = 1'b1;
                    end else begin
                        // The timeout keeps running across a bounce back to WAIT_LOCK.
                        to_cnt_nxt_s = to_cnt_r + TW'(1'b1);
                        if (lock_s) begin
                            stb_cnt_nxt_s = stb_cnt_r + SW'(1'b1);
                        end else begin
                            state_nxt_s = WAIT_LOCK;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt_s   = PLL_RST;
                        rst_cnt_nxt_s = {RW{1'b0}};
                        lost_nxt_s    = sat_inc8(lost_cnt);
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                FAIL: begin
                    state_nxt_s = FAIL;
                end
                default: begin
                    state_nxt_s   = PLL_RST;
                    rst_cnt_nxt_s = {RW{1'b0}};
                end
            endcase

            // Timeout: either give up or start another attempt.
            if (to_fire_s) begin
                if (retry_cnt == RETRY_MAX) begin
                    state_nxt_s = FAIL;
                end else begin
                    state_nxt_s   = PLL_RST;
                    rst_cnt_nxt_s = {RW{1'b0}};
                    retry_nxt_s   = retry_cnt + 4'd1;
                end
            end else begin
                retry_nxt_s = retry_nxt_s;
            end
        end

        pll_reset_nxt_s   = (state_nxt_s == PLL_RST) || (state_nxt_s == FAIL);
        sys_reset_n_nxt_s = (state_nxt_s == RUN);
        ready_nxt_s       = (state_nxt_s == RUN);
        fail_nxt_s        = (state_nxt_s == FAIL);
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl with directed scenarios and a
// randomized phase, compared every cycle against a phase/streak reference model.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES   = 8;
    localparam int LOCK_TIMEOUT = 256;
    localparam int LOCK_STABLE  = 16;
    localparam int MAX_RETRY    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lost_cnt;

    pll_lock_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an attempt is a reset pulse followed by a hunt.
    // The hunt ends in RUN after LOCK_STABLE+1 consecutive lock-high cycles,
    // or times out after LOCK_TIMEOUT cycles.
    localparam int PH_PULSE = 0;
    localparam int PH_HUNT  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DEAD  = 3;

    int   m_phase = PH_PULSE;
    int   m_cnt = 0;
    int   m_streak = 0;
    int   m_retry = 0;
    int   m_lost = 0;
    logic m_p1 = 1'b0;
    logic m_p2 = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic lk, input logic rr, input logic rs);
        logic ls;
        if (rs) begin
            m_phase = PH_PULSE; m_cnt = 0; m_streak = 0;
            m_retry = 0; m_lost = 0; m_p1 = 1'b0; m_p2 = 1'b0;
        end else begin
            ls = m_p2;
            m_p2 = m_p1;
            m_p1 = lk;
            if (rr) begin
                m_phase = PH_PULSE; m_cnt = 0; m_retry = 0;
            end else if (m_phase == PH_PULSE) begin
                m_cnt++;
                if (m_cnt == RST_CYCLES) begin
                    m_phase = PH_HUNT; m_cnt = 0; m_streak = 0;
                end
            end else if (m_phase == PH_HUNT) begin
                m_cnt++;
                m_streak = ls ? m_streak + 1 : 0;
                if (m_streak == LOCK_STABLE + 1) begin
                    m_phase = PH_RUN; m_retry = 0;
                end else if (m_cnt == LOCK_TIMEOUT) begin
                    if (m_retry == MAX_RETRY) begin
                        m_phase = PH_DEAD;
                    end else begin
                        m_retry++; m_phase = PH_PULSE; m_cnt = 0;
                    end
                end
            end else if (m_phase == PH_RUN) begin
                if (!ls) begin
                    m_phase = PH_PULSE; m_cnt = 0;
                    if (m_lost < 255) m_lost++;
                end
            end
        end
    endtask

    task automatic cmp_all();
        chk("m_pll_reset", int'(pll_reset), (m_phase == PH_PULSE || m_phase == PH_DEAD) ? 1 : 0);
        chk("m_sys_reset_n", int'(sys_reset_n), (m_phase == PH_RUN) ? 1 : 0);
        chk("m_ready", int'(ready), (m_phase == PH_RUN) ? 1 : 0);
        chk("m_fail", int'(fail), (m_phase == PH_DEAD) ? 1 : 0);
        chk("m_retry_cnt", int'(retry_cnt), m_retry);
        chk("m_lost_cnt", int'(lost_cnt), m_lost);
    endtask

    task automatic step(input logic lk, input logic rr, input logic rs);
        pll_lock = lk; relock_req = rr; reset = rs;
        @(posedge clk);
        model_step(lk, rr, rs);
        #1;
        cmp_all();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_reset"}, int'(pll_reset), 1);
        chk({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
        chk({tag, "_lost"}, int'(lost_cnt), 0);
    endtask

    // Starting on the edge that entered the reset pulse: 8-cycle pulse, lock
    // applied 10 cycles after release, ready 18 cycles after lock is sampled.
    task automatic acquire(input string tag);
        repeat (RST_CYCLES - 1) step(1'b0, 1'b0, 1'b0);
        chk({tag, "_pulse_hi"}, int'(pll_reset), 1);
        step(1'b0, 1'b0, 1'b0);
        chk({tag, "_pulse_lo"}, int'(pll_reset), 0);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        repeat (18) step(1'b1, 1'b0, 1'b0);
        chk({tag, "_not_yet"}, int'(ready), 0);
        step(1'b1, 1'b0, 1'b0);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_sysrst"}, int'(sys_reset_n), 1);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    task automatic run_until_ready(input string tag);
        int k = 0;
        while (!ready && k < 200) begin
            step(1'b1, 1'b0, 1'b0);
            k++;
        end
        chk({tag, "_reached"}, int'(ready), 1);
    endtask

    initial begin
        int hi_cnt;
        int rises;
        logic prev;
        int seg_len;
        logic seg_lvl;

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_reset_vals("rst");

        // Clean acquisition
        acquire("acq1");

        // Lock loss in RUN: outputs drop two edges after the sample
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_t1_ready", int'(ready), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_ready", int'(ready), 0);
        chk("loss_sysrst", int'(sys_reset_n), 0);
        chk("loss_pll_reset", int'(pll_reset), 1);
        chk("loss_lost", int'(lost_cnt), 1);
        acquire("reacq");

        // Single-cycle glitch during debounce
        step(1'b0, 1'b1, 1'b0);
        repeat (RST_CYCLES) step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (18) step(1'b1, 1'b0, 1'b0);
        chk("glitch_not_yet", int'(ready), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("glitch_ready", int'(ready), 1);

        // Reset in the middle of debounce
        step(1'b0, 1'b1, 1'b0);
        repeat (RST_CYCLES) step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_reset_vals("rst_deb");

        // Reset in RUN after five lock losses
        run_until_ready("l0");
        for (int i = 0; i < 4; i++) begin
            repeat (3) step(1'b0, 1'b0, 1'b0);
            run_until_ready("lx");
        end
        chk("lost_four", int'(lost_cnt), 4);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        run_until_ready("l5");
        chk("lost_five", int'(lost_cnt), 5);
        step(1'b1, 1'b0, 1'b1);
        chk_reset_vals("rst_run");

        // Lock never arrives: four pulses then FAIL at 1056 cycles
        hi_cnt = int'(pll_reset);
        rises = 0;
        prev = pll_reset;
        for (int i = 0; i < 1055; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (pll_reset) hi_cnt++;
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
        end
        chk("nolock_hi_cycles", hi_cnt, 4 * RST_CYCLES);
        chk("nolock_rises", rises, 3);
        chk("nolock_fail_early", int'(fail), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("nolock_fail", int'(fail), 1);
        chk("nolock_retry", int'(retry_cnt), 3);
        chk("nolock_pll_reset", int'(pll_reset), 1);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        chk("fail_sticky", int'(fail), 1);

        // Relock out of FAIL
        step(1'b0, 1'b1, 1'b0);
        chk("relock_fail", int'(fail), 0);
        chk("relock_retry", int'(retry_cnt), 0);
        chk("relock_pll_reset", int'(pll_reset), 1);
        acquire("relock");

        // Lock-loss counter saturation
        for (int i = 0; i < 260; i++) begin
            repeat (3) step(1'b0, 1'b0, 1'b0);
            run_until_ready("sat");
        end
        chk("lost_sat", int'(lost_cnt), 255);

        // Randomized lock behaviour with occasional relock and reset
        for (int s = 0; s < 300; s++) begin
            seg_len = int'($urandom_range(1, 40));
            seg_lvl = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
            for (int c = 0; c < seg_len; c++) begin
                step(seg_lvl, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
